reaction_timer_ctrl: RTL and testbench

Controller that sequences the free-running 7-bit LFSR into a reaction-time game. It lets the LFSR run while idle, freezes and samples it on start, and converts the sample into a random millisecond delay before lighting the LED. It then times the user's stop press in milliseconds and flags early presses. It sits between the debounced KEY inputs, the `lfsr7` instance and the BCD/7-segment display path.

---
 rtl/reaction_timer_ctrl_if.sv | 23 ++
 rtl/reaction_timer_ctrl.sv | 129 ++++++++++++
 tb/tb_reaction_timer_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/reaction_timer_ctrl_if.sv
// Handshake bundle between the reaction-timer controller and its surroundings:
// debounced keys and LFSR sample in, LFSR enable and game status out.
interface reaction_timer_ctrl_if;
  logic        start;
  logic        stop;
  logic [6:0]  rnd;
  logic        lfsr_en;
  logic        led;
  logic [13:0] time_ms;
  logic        busy;
  logic        done;
  logic        cheat;

  modport master (
    output start, stop, rnd,
    input  lfsr_en, led, time_ms, busy, done, cheat
  );

  modport slave (
    input  start, stop, rnd,
    output lfsr_en, led, time_ms, busy, done, cheat
  );
endinterface

// File: rtl/reaction_timer_ctrl.sv
// Reaction-time game sequencer: freezes the LFSR on start, waits a random number of ms,
// lights the LED and measures the stop press in ms, flagging presses that come too early.
module reaction_timer_ctrl #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned SCALE_MS     = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  reaction_timer_ctrl_if.slave        if_ctrl
);

  localparam int unsigned TickW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [13:0] MinDelay = 14'(MIN_DELAY_MS);
  localparam logic [13:0] Scale    = 14'(SCALE_MS);
  localparam logic [13:0] TimeMax  = 14'd9999;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StReact,
    StShow,
    StCheat
  } state_e;

  state_e             r_state, w_state_d;
  logic [13:0]        r_delay_ms, w_delay_ms_d;
  logic [TickW-1:0]   r_tick_cnt, w_tick_cnt_d;
  logic               r_led, w_led_d;
  logic [13:0]        r_time_ms, w_time_ms_d;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic               r_cheat, w_cheat_d;

  logic               w_tick;
  logic [6:0]         w_rnd_eff;
  logic [13:0]        w_delay_load;

  assign w_tick = (r_tick_cnt == TickW'(TICK_DIV - 1));

  // An all-zero LFSR sample is its lock-up state; treat it as 1.
  assign w_rnd_eff    = (if_ctrl.rnd == 7'd0) ? 7'd1 : if_ctrl.rnd;
  assign w_delay_load = MinDelay + {7'd0, w_rnd_eff} * Scale;

  always_comb begin
    w_state_d    = r_state;
    w_delay_ms_d = r_delay_ms;
    w_tick_cnt_d = w_tick ? '0 : r_tick_cnt + 1'b1;
    w_led_d      = r_led;
    w_time_ms_d  = r_time_ms;
    w_done_d     = 1'b0;
    w_cheat_d    = r_cheat;

    unique case (r_state)
      StIdle, StShow, StCheat: begin
        if (if_ctrl.start) begin
          w_state_d   = StArm;
          w_cheat_d   = 1'b0;
          w_time_ms_d = '0;
        end
      end
      StArm: begin
        w_delay_ms_d = w_delay_load;
        w_tick_cnt_d = '0;
        w_state_d    = StWait;
      end
      StWait: begin
        // stop has priority over tick, so a press on the final tick still counts as early
        if (if_ctrl.stop) begin
          w_state_d   = StCheat;
          w_cheat_d   = 1'b1;
          w_led_d     = 1'b0;
          w_time_ms_d = '0;
        end else if (w_tick) begin
          w_delay_ms_d = r_delay_ms - 14'd1;
          if (r_delay_ms == 14'd1) begin
            w_state_d    = StReact;
            w_led_d      = 1'b1;
            w_time_ms_d  = '0;
            w_tick_cnt_d = '0;
          end
        end
      end
      StReact: begin
        if (if_ctrl.stop) begin
          w_state_d = StShow;
          w_led_d   = 1'b0;
          w_done_d  = 1'b1;
        end else if (w_tick) begin
          w_time_ms_d = (r_time_ms >= TimeMax) ? TimeMax : r_time_ms + 14'd1;
        end
      end
      default: w_state_d = StIdle;
    endcase

    w_busy_d = (w_state_d == StArm) || (w_state_d == StWait) || (w_state_d == StReact);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_delay_ms <= '0;
      r_tick_cnt <= '0;
      r_led      <= 1'b0;
      r_time_ms  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cheat    <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_delay_ms <= w_delay_ms_d;
      r_tick_cnt <= w_tick_cnt_d;
      r_led      <= w_led_d;
      r_time_ms  <= w_time_ms_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_cheat    <= w_cheat_d;
    end
  end

  assign if_ctrl.lfsr_en = (r_state == StIdle) || (r_state == StShow) || (r_state == StCheat);
  assign if_ctrl.led     = r_led;
  assign if_ctrl.time_ms = r_time_ms;
  assign if_ctrl.busy    = r_busy;
  assign if_ctrl.done    = r_done;
  assign if_ctrl.cheat   = r_cheat;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// Bench for reaction_timer_ctrl: directed and random runs compared against an
// arithmetic model of delay length, reaction time and early-press detection.
module tb_reaction_timer_ctrl;

  localparam int TickDiv = 4;
  localparam int MinMs   = 2;
  localparam int ScaleMs = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  reaction_timer_ctrl_if bus ();

  reaction_timer_ctrl #(
    .TICK_DIV     (TickDiv),
    .MIN_DELAY_MS (MinMs),
    .SCALE_MS     (ScaleMs)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .if_ctrl (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles from WAIT entry until the LED lights.
  function automatic int wait_cycles(input int rnd);
    int r;
    r = (rnd == 0) ? 1 : rnd;
    return (MinMs + r * ScaleMs) * TickDiv;
  endfunction

  // Stop sampled r edges after the LED edge: it was presented r-1 whole cycles after the LED.
  function automatic int react_ms(input int r);
    int ms;
    ms = (r - 1) / TickDiv;
    return (ms > 9999) ? 9999 : ms;
  endfunction

  // One game: start (optionally with stop), then stop sampled s edges after WAIT entry.
  task automatic run(input string tag, input int rnd, input int s, input bit noisy,
                     input bit both);
    int w;
    int rise;
    w    = wait_cycles(rnd);
    rise = -1;
    bus.rnd   = 7'(rnd);
    bus.start = 1'b1;
    bus.stop  = both;
    cyc();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check({tag, ":arm_busy"}, 32'(bus.busy), 32'd1);
    check({tag, ":arm_lfsr_en"}, 32'(bus.lfsr_en), 32'd0);
    check({tag, ":arm_cheat"}, 32'(bus.cheat), 32'd0);
    check({tag, ":arm_time"}, 32'(bus.time_ms), 32'd0);
    check({tag, ":arm_done"}, 32'(bus.done), 32'd0);
    cyc();
    for (int i = 1; i <= s; i++) begin
      bus.stop  = (i == s);
      bus.start = noisy && (i != s) && (i % 7 == 3);
      cyc();
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      if (i < s && rise < 0 && bus.led === 1'b1) rise = i;
      if (i == s - 1 && s > w + 1)
        check({tag, ":pre_stop_time"}, 32'(bus.time_ms), 32'(react_ms(s - w)));
    end
    if (s > w) begin
      check({tag, ":led_rise"}, 32'(rise), 32'(w));
      check({tag, ":done"}, 32'(bus.done), 32'd1);
      check({tag, ":time"}, 32'(bus.time_ms), 32'(react_ms(s - w)));
      check({tag, ":cheat"}, 32'(bus.cheat), 32'd0);
    end else begin
      check({tag, ":led_never"}, 32'(rise), 32'hFFFF_FFFF);
      check({tag, ":cheat"}, 32'(bus.cheat), 32'd1);
      check({tag, ":done"}, 32'(bus.done), 32'd0);
      check({tag, ":time"}, 32'(bus.time_ms), 32'd0);
    end
    check({tag, ":led_off"}, 32'(bus.led), 32'd0);
    check({tag, ":busy_off"}, 32'(bus.busy), 32'd0);
    cyc();
    check({tag, ":done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, ":lfsr_en"}, 32'(bus.lfsr_en), 32'd1);
  endtask

  initial begin
    int n;
    int r;
    int w;
    int s;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.rnd   = 7'd0;
    rst = 1'b1;
    cyc();
    cyc();
    check("rst:led", 32'(bus.led), 32'd0);
    check("rst:time", 32'(bus.time_ms), 32'd0);
    check("rst:busy", 32'(bus.busy), 32'd0);
    check("rst:done", 32'(bus.done), 32'd0);
    check("rst:cheat", 32'(bus.cheat), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle:lfsr_en", 32'(bus.lfsr_en), 32'd1);
    end

    run("basic", 5, 28 + 13, 1'b0, 1'b0);
    run("early", 5, 10, 1'b0, 1'b0);
    run("restart", 5, 28 + 6, 1'b0, 1'b0);
    run("rnd0", 0, 12 + 5, 1'b0, 1'b0);
    run("rnd127", 127, 516 + 9, 1'b0, 1'b0);
    run("final_tick", 3, wait_cycles(3), 1'b0, 1'b0);
    run("same_tick", 2, wait_cycles(2) + 8, 1'b0, 1'b0);
    run("noisy", 7, wait_cycles(7) + 30, 1'b1, 1'b0);
    run("show_both", 9, wait_cycles(9) + 21, 1'b0, 1'b1);
    run("saturate", 0, 12 + 4 * 10005 + 1, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      r = int'($urandom_range(0, 127));
      w = wait_cycles(r);
      if ($urandom_range(0, 2) == 0) s = int'($urandom_range(1, w));
      else s = w + int'($urandom_range(1, 60));
      run($sformatf("rand%0d", k), r, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of REACT
    bus.rnd   = 7'd0;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    n = 0;
    while (bus.led !== 1'b1 && n < 600) begin
      cyc();
      n++;
    end
    check("rst_react:led_rise", 32'(n), 32'd12);
    repeat (10) cyc();
    check("rst_react:time_before", 32'(bus.time_ms), 32'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("rst_react:led", 32'(bus.led), 32'd0);
    check("rst_react:time", 32'(bus.time_ms), 32'd0);
    check("rst_react:busy", 32'(bus.busy), 32'd0);
    check("rst_react:done", 32'(bus.done), 32'd0);
    check("rst_react:cheat", 32'(bus.cheat), 32'd0);
    check("rst_react:lfsr_en", 32'(bus.lfsr_en), 32'd1);
    run("after_rst", 4, wait_cycles(4) + 3, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
